// File: rtl/gcd_sched_pkg.sv
// Shared types, default sizes and request-bus slicing helper for the GCD engine scheduler.
package gcd_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 16;

  // LSB of requester idx's {a, b} field within the flat request data bus.
  function automatic int req_lsb(input int idx, input int data_w);
    return idx * 2 * data_w;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after ptr wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N; k++) begin
      cand = IW'((int'(ptr) + k) % N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        idx       = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one GCD engine among NUM_REQ requesters, with per-requester response slots.
// Define GCD_SCHED_BYPASS_EN to complete requests with a zero operand locally (result a|b) without the engine.
module gcd_sched
  import gcd_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            io_req_valid,
  input  logic [NUM_REQ*2*DATA_W-1:0]   io_req_data,
  output logic [NUM_REQ-1:0]            io_req_ready,
  output logic [NUM_REQ-1:0]            io_rsp_valid,
  output logic [NUM_REQ*DATA_W-1:0]     io_rsp_data,
  input  logic [NUM_REQ-1:0]            io_rsp_ready,
  output logic                          io_eng_in_valid,
  output logic [2*DATA_W-1:0]           io_eng_in_data,
  input  logic                          io_eng_in_ready,
  input  logic                          io_eng_out_valid,
  input  logic [DATA_W-1:0]             io_eng_out_data,
  output logic                          io_busy
);

  localparam int IW = $clog2(NUM_REQ);

  state_t                         state, state_nxt;
  logic [IW-1:0]                  rr_ptr, owner, win_idx;
  logic [NUM_REQ-1:0]             slot_full, elig, win_gnt;
  logic [NUM_REQ-1:0][DATA_W-1:0] slot;
  logic                           win_any, bypass, accept, issue;
  logic [2*DATA_W-1:0]            win_data;

  // Registered slot_full: a slot draining this cycle still blocks its owner.
  assign elig = io_req_valid & ~slot_full;

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
    .req (elig),
    .ptr (rr_ptr),
    .gnt (win_gnt),
    .idx (win_idx),
    .any (win_any)
  );

  assign win_data = io_req_data[req_lsb(int'(win_idx), DATA_W) +: 2*DATA_W];

`ifdef GCD_SCHED_BYPASS_EN
  logic [DATA_W-1:0] win_a, win_b;
  assign win_a  = win_data[2*DATA_W-1:DATA_W];
  assign win_b  = win_data[DATA_W-1:0];
  assign bypass = win_any && ((win_a == '0) || (win_b == '0));
`else
  assign bypass = 1'b0;
`endif

  assign io_eng_in_data = win_data;
  assign io_rsp_valid   = slot_full;
  assign io_rsp_data    = slot;
  assign io_busy        = (state == WAIT);

  // Handshake outputs are combinational, so reset gates them to keep them low asynchronously.
  always_comb begin
    state_nxt       = state;
    io_eng_in_valid = 1'b0;
    io_req_ready    = '0;
    accept          = 1'b0;
    issue           = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (win_any) begin
            if (bypass) begin
              io_req_ready = win_gnt;
              accept       = 1'b1;
            end else begin
              io_eng_in_valid = 1'b1;
              if (io_eng_in_ready) begin
                io_req_ready = win_gnt;
                accept       = 1'b1;
                issue        = 1'b1;
                state_nxt    = WAIT;
              end
            end
          end
        end
        WAIT: begin
          if (io_eng_out_valid) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      slot      <= '0;
      slot_full <= '0;
    end else begin
      state <= state_nxt;
      if (accept) rr_ptr <= IW'((int'(win_idx) + 1) % NUM_REQ);
      if (issue)  owner  <= win_idx;
      slot_full <= slot_full & ~io_rsp_ready;
      // Fill never collides with a drain: the owner was granted with its slot empty.
      if ((state == WAIT) && io_eng_out_valid) begin
        slot[owner]      <= io_eng_out_data;
        slot_full[owner] <= 1'b1;
      end
`ifdef GCD_SCHED_BYPASS_EN
      if (accept && bypass) begin
        slot[win_idx]      <= win_a | win_b;
        slot_full[win_idx] <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a behavioural fixed-latency GCD engine and a per-requester scoreboard.
module tb_gcd_sched;

  localparam int NR      = 4;
  localparam int DW      = 16;
  localparam int ENG_LAT = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR-1:0]        io_req_valid, io_req_ready, io_rsp_valid, io_rsp_ready;
  logic [NR*2*DW-1:0]   io_req_data;
  logic [NR*DW-1:0]     io_rsp_data;
  logic                 io_eng_in_valid, io_eng_in_ready, io_eng_out_valid, io_busy;
  logic [2*DW-1:0]      io_eng_in_data;
  logic [DW-1:0]        io_eng_out_data;

  logic                 eng_busy, eng_pulse, spur;
  logic [3:0]           eng_cnt;
  logic [DW-1:0]        eng_res;

  logic [2*DW-1:0]      pend  [NR][$];
  logic [DW-1:0]        exp_q [NR][$];
  int                   grant_q[$];
  logic [NR-1:0]        acc_seen;
  logic                 pulse_seen;
  int                   n_cmp = 0;
  int                   n_err = 0;

  always #5 clk = ~clk;

  gcd_sched #(.NUM_REQ(NR), .DATA_W(DW)) dut (
    .clk              (clk),
    .reset            (reset),
    .io_req_valid     (io_req_valid),
    .io_req_data      (io_req_data),
    .io_req_ready     (io_req_ready),
    .io_rsp_valid     (io_rsp_valid),
    .io_rsp_data      (io_rsp_data),
    .io_rsp_ready     (io_rsp_ready),
    .io_eng_in_valid  (io_eng_in_valid),
    .io_eng_in_data   (io_eng_in_data),
    .io_eng_in_ready  (io_eng_in_ready),
    .io_eng_out_valid (io_eng_out_valid),
    .io_eng_out_data  (io_eng_out_data),
    .io_busy          (io_busy)
  );

  function automatic logic [DW-1:0] gcd16(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW-1:0] x, y, t;
    x = a;
    y = b;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // Engine: accepts when idle, pulses the result ENG_LAT cycles later, ready again in the pulse cycle.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      eng_busy        <= 1'b0;
      eng_cnt         <= '0;
      eng_pulse       <= 1'b0;
      eng_res         <= '0;
      io_eng_out_data <= '0;
    end else begin
      eng_pulse <= 1'b0;
      if (eng_busy) begin
        eng_cnt <= eng_cnt - 4'd1;
        if (eng_cnt == 4'd1) begin
          eng_busy        <= 1'b0;
          eng_pulse       <= 1'b1;
          io_eng_out_data <= eng_res;
        end
      end else if (io_eng_in_valid) begin
        eng_busy <= 1'b1;
        eng_cnt  <= 4'(ENG_LAT);
        eng_res  <= gcd16(io_eng_in_data[2*DW-1:DW], io_eng_in_data[DW-1:0]);
      end
    end
  end

  assign io_eng_in_ready  = !eng_busy;
  assign io_eng_out_valid = eng_pulse | spur;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input int r, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW-1:0] e);
    pend[r].push_back({a, b});
    exp_q[r].push_back(e);
  endtask

  task automatic refresh();
    for (int i = 0; i < NR; i++) begin
      io_req_valid[i] = (pend[i].size() != 0);
      io_req_data[i*2*DW +: 2*DW] = (pend[i].size() != 0) ? pend[i][0] : '0;
    end
  endtask

  task automatic mon();
    acc_seen   = io_req_valid & io_req_ready;
    pulse_seen = io_eng_out_valid;
    for (int i = 0; i < NR; i++) begin
      if (acc_seen[i]) grant_q.push_back(i);
      if (io_rsp_valid[i] && io_rsp_ready[i]) begin
        if (exp_q[i].size() == 0)
          check($sformatf("rsp%0d_unexpected", i), 64'(io_rsp_valid[i]), 64'd0);
        else
          check($sformatf("rsp%0d_data", i), 64'(io_rsp_data[i*DW +: DW]), 64'(exp_q[i].pop_front()));
      end
    end
  endtask

  // Sample 1 ns before the edge, then retire accepted requests just after it.
  task automatic cyc();
    @(negedge clk);
    #4;
    mon();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (acc_seen[i] && pend[i].size() != 0) pend[i].delete(0);
    refresh();
    #1;
  endtask

  function automatic bit drained(input logic [NR-1:0] m);
    for (int i = 0; i < NR; i++)
      if (m[i] && (pend[i].size() != 0 || exp_q[i].size() != 0)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int grant_at(input int k);
    return (k < grant_q.size()) ? grant_q[k] : -1;
  endfunction

  task automatic wait_drained(input logic [NR-1:0] m, input int budget, input string tag);
    int n = 0;
    while (!drained(m) && n < budget) begin
      cyc();
      n++;
    end
    check({tag, "_drain"}, 64'(drained(m)), 64'd1);
  endtask

  initial begin
    int n;
    reset        = 1'b1;
    spur         = 1'b0;
    io_req_valid = '0;
    io_req_data  = '0;
    io_rsp_ready = '1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_req_ready", 64'(io_req_ready), 64'd0);
    check("rst_rsp_valid", 64'(io_rsp_valid), 64'd0);
    check("rst_eng_valid", 64'(io_eng_in_valid), 64'd0);
    check("rst_busy", 64'(io_busy), 64'd0);
    reset = 1'b0;

    // Single request {48,18}.
    push(0, 16'd48, 16'd18, 16'd6);
    refresh();
    #1;
    check("t1_eng_valid", 64'(io_eng_in_valid), 64'd1);
    check("t1_eng_data", 64'(io_eng_in_data), 64'h0030_0012);
    check("t1_req_ready", 64'(io_req_ready), 64'b0001);
    cyc();
    check("t1_busy", 64'(io_busy), 64'd1);
    check("t1_wait_eng_valid", 64'(io_eng_in_valid), 64'd0);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!pulse_seen && n < 20);
    check("t1_pulse_seen", 64'(pulse_seen), 64'd1);
    check("t1_rsp_valid", 64'(io_rsp_valid), 64'b0001);
    check("t1_rsp_data", 64'(io_rsp_data[DW-1:0]), 64'd6);
    check("t1_busy_after", 64'(io_busy), 64'd0);
    wait_drained(4'b0001, 10, "t1");

    // Result pulse while idle must be ignored.
    spur = 1'b1;
    cyc();
    spur = 1'b0;
    cyc();
    check("spur_rsp_valid", 64'(io_rsp_valid), 64'd0);
    check("spur_busy", 64'(io_busy), 64'd0);

    // Two requesters valid through reset.
    reset = 1'b1;
    push(0, 16'd12, 16'd8, 16'd4);
    push(1, 16'd9, 16'd6, 16'd3);
    refresh();
    #1;
    check("t2_rst_req_ready", 64'(io_req_ready), 64'd0);
    check("t2_rst_eng_valid", 64'(io_eng_in_valid), 64'd0);
    check("t2_rst_rsp_data", 64'(io_rsp_data), 64'd0);
    grant_q.delete();
    cyc();
    reset = 1'b0;
    wait_drained(4'b0011, 40, "t2");
    check("t2_grants", 64'(grant_q.size()), 64'd2);
    check("t2_grant0", 64'(grant_at(0)), 64'd0);
    check("t2_grant1", 64'(grant_at(1)), 64'd1);
    check("t2_rr_ptr", 64'(dut.rr_ptr), 64'd2);

    // Requester 2 holds a full slot; requester 3 must win meanwhile.
    io_rsp_ready = 4'b1011;
    push(2, 16'd30, 16'd12, 16'd6);
    refresh();
    n = 0;
    while (!io_rsp_valid[2] && n < 30) begin
      cyc();
      n++;
    end
    check("t3_slot2_full", 64'(io_rsp_valid[2]), 64'd1);
    grant_q.delete();
    push(2, 16'd10, 16'd4, 16'd2);
    push(3, 16'd15, 16'd10, 16'd5);
    refresh();
    #1;
    check("t3_req_ready", 64'(io_req_ready), 64'b1000);
    check("t3_eng_data", 64'(io_eng_in_data), 64'h000F_000A);
    wait_drained(4'b1000, 40, "t3");
    check("t3_grants", 64'(grant_q.size()), 64'd1);
    check("t3_grant0", 64'(grant_at(0)), 64'd3);
    check("t3_slot2_hold_vld", 64'(io_rsp_valid[2]), 64'd1);
    check("t3_slot2_hold_dat", 64'(io_rsp_data[2*DW +: DW]), 64'd6);
    check("t3_blocked", 64'(io_req_ready), 64'd0);
    io_rsp_ready = 4'b1111;
    #1;
    check("t3_drain_cycle", 64'(io_req_ready), 64'd0);
    cyc();
    check("t3_after_drain", 64'(io_req_ready), 64'b0100);
    check("t3_after_data", 64'(io_eng_in_data), 64'h000A_0004);
    wait_drained(4'b1111, 40, "t3b");

    // Reset in the middle of a job.
    push(1, 16'd100, 16'd75, 16'd25);
    refresh();
    n = 0;
    do begin
      cyc();
      n++;
    end while (!io_busy && n < 10);
    check("t5_busy", 64'(io_busy), 64'd1);
    reset = 1'b1;
    #1;
    check("t5_rst_busy", 64'(io_busy), 64'd0);
    check("t5_rst_req_ready", 64'(io_req_ready), 64'd0);
    check("t5_rst_eng_valid", 64'(io_eng_in_valid), 64'd0);
    check("t5_rst_rsp_valid", 64'(io_rsp_valid), 64'd0);
    exp_q[1].delete();
    cyc();
    reset = 1'b0;
    push(3, 16'd21, 16'd14, 16'd7);
    refresh();
    wait_drained(4'b1111, 40, "t5");

    // All requesters continuously valid.
    grant_q.delete();
    for (int j = 0; j < 2; j++)
      for (int i = 0; i < NR; i++)
        push(i, 16'(6 * (i + 2) * (j + 1)), 16'(4 * (i + 1)),
             gcd16(16'(6 * (i + 2) * (j + 1)), 16'(4 * (i + 1))));
    refresh();
    wait_drained(4'b1111, 200, "t4");
    check("t4_grants", 64'(grant_q.size()), 64'd8);
    for (int k = 0; k < 8; k++)
      check($sformatf("t4_grant%0d", k), 64'(grant_at(k)), 64'(k % NR));

`ifdef GCD_SCHED_BYPASS_EN
    push(1, 16'd7, 16'd0, 16'd7);
    refresh();
    #1;
    check("byp_eng_valid", 64'(io_eng_in_valid), 64'd0);
    check("byp_req_ready", 64'(io_req_ready), 64'b0010);
    cyc();
    check("byp_rsp_valid", 64'(io_rsp_valid[1]), 64'd1);
    check("byp_rsp_data", 64'(io_rsp_data[DW +: DW]), 64'd7);
    check("byp_busy", 64'(io_busy), 64'd0);
    push(2, 16'd0, 16'd0, 16'd0);
    refresh();
    #1;
    check("byp0_eng_valid", 64'(io_eng_in_valid), 64'd0);
    cyc();
    check("byp0_rsp_valid", 64'(io_rsp_valid[2]), 64'd1);
    check("byp0_rsp_data", 64'(io_rsp_data[2*DW +: DW]), 64'd0);
    wait_drained(4'b1111, 20, "byp");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
